reconstruct_l5: RTL and testbench

Fifth-level wavelet synthesis stage, the inverse of the L5 decomposition. It takes one (a5, d5) coefficient pair at most every 2 cycles, upsamples by 2, and applies the 8-tap reconstruction low-pass (G) and high-pass (H) filters in polyphase form. It emits one a4 coefficient per cycle. It sits at the head of the reconstruction chain, feeding the L4 synthesis stage.

---
 rtl/wavelet_pkg.sv | 28 ++
 rtl/recon_mac8.sv | 45 ++++
 rtl/reconstruct_l5.sv | 188 ++++++++++++++++++
 tb/tb_reconstruct_l5.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared constants for the wavelet reconstruction chain: default widths,
// sym4 synthesis taps (Q2.23) and the synthesis-stage FSM encoding.
package wavelet_pkg;

  localparam int DEF_INTERNAL_WIDTH = 48;
  localparam int DEF_COEF_WIDTH     = 25;
  localparam int DEF_COEF_FRAC      = 23;

  localparam int N_TAPS = 8;
  localparam int N_HIST = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } recon_state_e;

  localparam logic signed [DEF_COEF_WIDTH-1:0] SYM4_REC_G [N_TAPS] = '{
    25'sd270307,  -25'sd105730, -25'sd832314, 25'sd2498612,
    25'sd6742249, 25'sd4174328, -25'sd248601, -25'sd635569
  };

  localparam logic signed [DEF_COEF_WIDTH-1:0] SYM4_REC_H [N_TAPS] = '{
    -25'sd635569, 25'sd248601,  25'sd4174328, -25'sd6742249,
    25'sd2498612, 25'sd832314,  -25'sd105730, -25'sd270307
  };

endpackage

// File: rtl/recon_mac8.sv
// recon_mac8: eight signed full-precision multipliers followed by a 3-level
// adder tree; products registered in p0, the sum registered in p1.
module recon_mac8
  import wavelet_pkg::*;
#(
  parameter int DATA_W = DEF_INTERNAL_WIDTH,
  parameter int COEF_W = DEF_COEF_WIDTH
) (
  input  logic                             clk,
  input  logic signed [DATA_W-1:0]         x [N_TAPS],
  input  logic signed [COEF_W-1:0]         c [N_TAPS],
  output logic signed [DATA_W+COEF_W+2:0]  sum_p1
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 3;

  logic signed [PROD_W-1:0] prod_p0 [N_TAPS];
  logic signed [SUM_W-1:0]  lvl1 [N_TAPS/2];
  logic signed [SUM_W-1:0]  lvl2 [N_TAPS/4];
  logic signed [SUM_W-1:0]  sum_c;

  // Stage p0: one product per tap, both operands sign-extended to full width
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TAPS; i++) begin
      prod_p0[i] <= PROD_W'(x[i]) * PROD_W'(c[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < N_TAPS/2; i++) begin
      lvl1[i] = SUM_W'(prod_p0[2*i]) + SUM_W'(prod_p0[2*i+1]);
    end
    for (int i = 0; i < N_TAPS/4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    sum_c = lvl2[0] + lvl2[1];
  end

  // Stage p1: three guard bits keep the 8-term sum exact
  always_ff @(posedge clk) begin
    sum_p1 <= sum_c;
  end

endmodule

// File: rtl/reconstruct_l5.sv
// reconstruct_l5: L5 wavelet synthesis, polyphase 8-tap G/H on a 2-phase
// time-shared MAC. Optional macro RECON_WARMUP_EN hides the first 3 pairs.
module reconstruct_l5
  import wavelet_pkg::*;
#(
  parameter int INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
  parameter int COEF_WIDTH     = DEF_COEF_WIDTH,
  parameter int COEF_FRAC      = DEF_COEF_FRAC,
  parameter logic signed [COEF_WIDTH-1:0] REC_G0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G7 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H7 = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             din_valid,
  output logic                             din_ready,
  input  logic signed [INTERNAL_WIDTH-1:0] a5_in,
  input  logic signed [INTERNAL_WIDTH-1:0] d5_in,
  output logic                             dout_valid,
  output logic signed [INTERNAL_WIDTH-1:0] a4_out,
  output logic                             ovf_err
);

  localparam int PROD_W = INTERNAL_WIDTH + COEF_WIDTH;
  localparam int SUM_W  = PROD_W + 3;

  localparam logic signed [COEF_WIDTH-1:0] G_TAP [N_TAPS] = '{
    REC_G0, REC_G1, REC_G2, REC_G3, REC_G4, REC_G5, REC_G6, REC_G7
  };
  localparam logic signed [COEF_WIDTH-1:0] H_TAP [N_TAPS] = '{
    REC_H0, REC_H1, REC_H2, REC_H3, REC_H4, REC_H5, REC_H6, REC_H7
  };

  recon_state_e                     state;
  logic                             accept;
  logic                             launch;
  logic                             launch_ok;
  logic                             vld_p0;
  logic                             vld_p1;
  logic signed [INTERNAL_WIDTH-1:0] a_hist [N_HIST];
  logic signed [INTERNAL_WIDTH-1:0] d_hist [N_HIST];
  logic signed [INTERNAL_WIDTH-1:0] mac_x  [N_TAPS];
  logic signed [COEF_WIDTH-1:0]     mac_c  [N_TAPS];
  logic signed [SUM_W-1:0]          sum_p1;

  // Arithmetic shift is a floor divide; the narrowing cast lets overflow wrap.
  function automatic logic signed [INTERNAL_WIDTH-1:0] trunc_floor(
    input logic signed [SUM_W-1:0] s
  );
    return INTERNAL_WIDTH'(s >>> COEF_FRAC);
  endfunction

  assign accept = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      din_ready <= 1'b1;
      ovf_err   <= 1'b0;
    end else begin
      if (din_valid && !din_ready) begin
        ovf_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_EVEN;
            din_ready <= 1'b0;
          end
        end
        ST_EVEN: begin
          state     <= ST_ODD;
          din_ready <= 1'b1;
        end
        ST_ODD: begin
          if (accept) begin
            state     <= ST_EVEN;
            din_ready <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            din_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          din_ready <= 1'b1;
        end
      endcase
    end
  end

  // An accept in ODD shifts history on the same edge the odd products are
  // captured, so the odd phase still multiplies the previous pair's history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_HIST; k++) begin
        a_hist[k] <= '0;
        d_hist[k] <= '0;
      end
    end else if (accept) begin
      a_hist[0] <= a5_in;
      d_hist[0] <= d5_in;
      for (int k = 1; k < N_HIST; k++) begin
        a_hist[k] <= a_hist[k-1];
        d_hist[k] <= d_hist[k-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_HIST; k++) begin
      mac_x[k]        = a_hist[k];
      mac_x[N_HIST+k] = d_hist[k];
      mac_c[k]        = (state == ST_ODD) ? G_TAP[2*k+1] : G_TAP[2*k];
      mac_c[N_HIST+k] = (state == ST_ODD) ? H_TAP[2*k+1] : H_TAP[2*k];
    end
  end

`ifdef RECON_WARMUP_EN
  logic [1:0] warm_cnt;
  logic       pair_warm;

  // pair_warm is latched per pair, so both phases of a pair agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt  <= '0;
      pair_warm <= 1'b0;
    end else if (accept) begin
      pair_warm <= (warm_cnt == 2'd3);
      if (warm_cnt != 2'd3) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  assign launch_ok = pair_warm;
`else
  assign launch_ok = 1'b1;
`endif

  assign launch = ((state == ST_EVEN) || (state == ST_ODD)) && launch_ok;

  recon_mac8 #(
    .DATA_W (INTERNAL_WIDTH),
    .COEF_W (COEF_WIDTH)
  ) u_mac (
    .clk    (clk),
    .x      (mac_x),
    .c      (mac_c),
    .sum_p1 (sum_p1)
  );

  // Stage p0/p1 valids track the products and sum inside u_mac
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      vld_p0     <= launch;
      vld_p1     <= vld_p0;
      dout_valid <= vld_p1;
    end
  end

  // Stage p2: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      a4_out <= '0;
    end else if (vld_p1) begin
      a4_out <= trunc_floor(sum_p1);
    end
  end

endmodule

// File: tb/tb_reconstruct_l5.sv
// Bench for reconstruct_l5: one DUT with integer G/H taps, one with G0=1 raw
// to expose floor truncation; table-driven pairs plus a cycle-stamped scoreboard.
module tb_reconstruct_l5;

  localparam logic signed [47:0] ONE = 48'sd8388608;

  typedef struct {
    logic signed [47:0] a5;
    logic signed [47:0] d5;
    logic signed [47:0] me;
    logic signed [47:0] mo;
    logic signed [47:0] te;
    logic signed [47:0] tod;
  } vec_t;

  typedef struct {
    int                 cyc;
    logic signed [47:0] val;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               din_valid;
  logic signed [47:0] a5_in;
  logic signed [47:0] d5_in;
  logic               din_ready_m, din_ready_t;
  logic               dout_valid_m, dout_valid_t;
  logic signed [47:0] a4_m, a4_t;
  logic               ovf_m, ovf_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc = 0;
  vec_t tbl [17];
  exp_t q_m [$];
  exp_t q_t [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reconstruct_l5 #(
    .COEF_WIDTH (28),
    .REC_G0 (28'sd8388608),  .REC_G1 (28'sd16777216),
    .REC_G2 (28'sd25165824), .REC_G3 (28'sd33554432),
    .REC_G4 (28'sd41943040), .REC_G5 (28'sd50331648),
    .REC_G6 (28'sd58720256), .REC_G7 (28'sd67108864),
    .REC_H0 (-28'sd8388608),  .REC_H1 (-28'sd16777216),
    .REC_H2 (-28'sd25165824), .REC_H3 (-28'sd33554432),
    .REC_H4 (-28'sd41943040), .REC_H5 (-28'sd50331648),
    .REC_H6 (-28'sd58720256), .REC_H7 (-28'sd67108864)
  ) u_main (
    .clk (clk), .rst (rst), .din_valid (din_valid), .din_ready (din_ready_m),
    .a5_in (a5_in), .d5_in (d5_in), .dout_valid (dout_valid_m),
    .a4_out (a4_m), .ovf_err (ovf_m)
  );

  reconstruct_l5 #(
    .REC_G0 (25'sd1)
  ) u_trunc (
    .clk (clk), .rst (rst), .din_valid (din_valid), .din_ready (din_ready_t),
    .a5_in (a5_in), .d5_in (d5_in), .dout_valid (dout_valid_t),
    .a4_out (a4_t), .ovf_err (ovf_t)
  );

  function automatic logic signed [47:0] qv(input int k);
    return ONE * k;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic score_out(input string name, input logic vld,
                           input logic signed [47:0] act, input logic signed [47:0] req);
    checks++;
    if (vld !== 1'b1) begin
      failures++;
      $display("FAIL dout_valid_%s cyc=%0d actual=%b required=1", name, cyc, vld);
    end else if (act !== req) begin
      failures++;
      $display("FAIL a4_%s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic signed [47:0] act);
    checks++;
    failures++;
    $display("FAIL spurious_valid_%s cyc=%0d actual=1 (a4=%0d) required=0", name, cyc, act);
  endtask

  always @(negedge clk) begin
    if (q_m.size() > 0 && q_m[0].cyc == cyc) begin
      score_out("main", dout_valid_m, a4_m, q_m[0].val);
      void'(q_m.pop_front());
    end else if (dout_valid_m === 1'b1) begin
      unexpected("main", a4_m);
    end
    if (q_t.size() > 0 && q_t[0].cyc == cyc) begin
      score_out("trunc", dout_valid_t, a4_t, q_t[0].val);
      void'(q_t.pop_front());
    end else if (dout_valid_t === 1'b1) begin
      unexpected("trunc", a4_t);
    end
  end

  // Offer one pair when the DUT is ready; expectations land at t+4 and t+5.
  task automatic send(input vec_t v);
    int  t;
    bit  got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (din_ready_m === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL din_ready_timeout cyc=%0d actual=0 required=1", cyc);
      return;
    end
    t = cyc;
    a5_in = v.a5;
    d5_in = v.d5;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    a5_in = '0;
    d5_in = '0;
`ifdef RECON_WARMUP_EN
    if (acc >= 3) begin
`else
    begin
`endif
      q_m.push_back('{t + 4, v.me});
      q_m.push_back('{t + 5, v.mo});
      q_t.push_back('{t + 4, v.te});
      q_t.push_back('{t + 5, v.tod});
    end
    acc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q_m.size() > 0 || q_t.size() > 0); i++) begin
      @(negedge clk);
    end
    if (q_m.size() > 0 || q_t.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q_m.size() + q_t.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // impulse on a5, then detail impulse, then truncation, then combined
    tbl[0]  = '{qv(1),  '0,      qv(1),  qv(2),  48'sd1,  '0};
    tbl[1]  = '{'0,     '0,      qv(3),  qv(4),  '0,      '0};
    tbl[2]  = '{'0,     '0,      qv(5),  qv(6),  '0,      '0};
    tbl[3]  = '{'0,     '0,      qv(7),  qv(8),  '0,      '0};
    tbl[4]  = '{'0,     qv(1),   qv(-1), qv(-2), '0,      '0};
    tbl[5]  = '{'0,     '0,      qv(-3), qv(-4), '0,      '0};
    tbl[6]  = '{'0,     '0,      qv(-5), qv(-6), '0,      '0};
    tbl[7]  = '{'0,     '0,      qv(-7), qv(-8), '0,      '0};
    tbl[8]  = '{-48'sd1, '0,     -48'sd1, -48'sd2, -48'sd1, '0};
    tbl[9]  = '{'0,     '0,      -48'sd3, -48'sd4, '0,      '0};
    tbl[10] = '{'0,     '0,      -48'sd5, -48'sd6, '0,      '0};
    tbl[11] = '{'0,     '0,      -48'sd7, -48'sd8, '0,      '0};
    tbl[12] = '{qv(1),  qv(-1),  qv(2),  qv(4),  48'sd1,  '0};
    tbl[13] = '{'0,     '0,      qv(6),  qv(8),  '0,      '0};
    tbl[14] = '{'0,     '0,      qv(10), qv(12), '0,      '0};
    tbl[15] = '{'0,     '0,      qv(14), qv(16), '0,      '0};
    tbl[16] = '{'0,     '0,      '0,     '0,     '0,      '0};

    rst = 1'b1;
    din_valid = 1'b0;
    a5_in = '0;
    d5_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    acc = 0;
    @(negedge clk);
    check("reset_din_ready", din_ready_m, 1);
    check("reset_dout_valid", dout_valid_m, 0);
    check("reset_a4_out", a4_m, 0);
    check("reset_ovf_err", ovf_m, 0);
    check("reset_din_ready_trunc", din_ready_t, 1);

    for (int i = 0; i < 17; i++) send(tbl[i]);
    drain();
    repeat (3) @(negedge clk);

    // Overrun during EVEN: pair dropped, flag sticks, outputs unchanged
    check("ovf_before", ovf_m, 0);
    send(tbl[0]);
    din_valid = 1'b1;
    a5_in = 48'sh123;
    d5_in = '0;
    @(negedge clk);
    check("overrun_din_ready", din_ready_m, 0);
    @(posedge clk);
    #1 din_valid = 1'b0;
    a5_in = '0;
    @(negedge clk);
    check("ovf_main", ovf_m, 1);
    check("ovf_trunc", ovf_t, 1);
    for (int i = 1; i < 4; i++) send(tbl[i]);
    send(tbl[16]);
    drain();
    check("ovf_sticky", ovf_m, 1);

    // Reset two cycles after an accept discards the in-flight pair
    send(tbl[0]);
    q_m.delete();
    q_t.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acc = 0;
    @(negedge clk);
    check("midrst_a4_out", a4_m, 0);
    check("midrst_din_ready", din_ready_m, 1);
    check("midrst_dout_valid", dout_valid_m, 0);
    check("midrst_ovf_clear", ovf_m, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) send(tbl[i]);
    send(tbl[16]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
